// File: rtl/interval_meter_if.sv
// Control and result bundle for interval_meter: async start/stop/clear levels
// in, captured interval and status flags out.
interface interval_meter_if #(
  parameter int C_COUNTER_WIDTH = 32
);
  logic                       start;
  logic                       stop;
  logic                       clear;
  logic [C_COUNTER_WIDTH-1:0] interval;
  logic                       valid;
  logic                       busy;
  logic                       overflow;

  modport master (
    output start, stop, clear,
    input  interval, valid, busy, overflow
  );

  modport slave (
    input  start, stop, clear,
    output interval, valid, busy, overflow
  );
endinterface

// File: rtl/interval_meter.sv
// Counts clk cycles between a start edge and the next stop edge, holding the
// saturating result until a clear edge; all three inputs are asynchronous.
module interval_meter #(
  parameter int C_COUNTER_WIDTH = 32,
  parameter int C_SYNC_STAGES   = 2
) (
  input logic           clk,
  input logic           reset,
  interval_meter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  localparam logic [C_COUNTER_WIDTH-1:0] COUNT_MAX = '1;

  logic [2:0] async_in;
  logic [2:0] pulse;
  logic       start_p;
  logic       stop_p;
  logic       clear_p;

  assign async_in = {bus.clear, bus.stop, bus.start};

  // Identical conditioning on every input keeps the pulse latency equal, so it
  // cancels out of the measured interval.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cond
      logic [C_SYNC_STAGES-1:0] sync_reg;
      logic                     prev_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg <= '0;
          prev_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[C_SYNC_STAGES-2:0], async_in[gi]};
          prev_reg <= sync_reg[C_SYNC_STAGES-1];
        end
      end

      assign pulse[gi] = sync_reg[C_SYNC_STAGES-1] & ~prev_reg;
    end
  endgenerate

  assign start_p = pulse[0];
  assign stop_p  = pulse[1];
  assign clear_p = pulse[2];

  state_t                     state_reg, state_next;
  logic [C_COUNTER_WIDTH-1:0] count_reg, count_next;
  logic [C_COUNTER_WIDTH-1:0] interval_reg, interval_next;
  logic                       overflow_reg, overflow_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      interval_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      interval_reg <= interval_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    interval_next = interval_reg;
    overflow_next = overflow_reg;

    if (clear_p) begin
      state_next    = IDLE;
      count_next    = '0;
      interval_next = '0;
      overflow_next = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start_p) begin
            state_next = COUNT;
            count_next = {{(C_COUNTER_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        COUNT: begin
          if (stop_p) begin
            state_next    = HOLD;
            interval_next = count_reg;
          end else if (count_reg == COUNT_MAX) begin
            // Saturated: the count sticks and the flag records it.
            overflow_next = 1'b1;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
        HOLD: begin
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (state_reg == COUNT);
  assign bus.valid    = (state_reg == HOLD);
  assign bus.interval = interval_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: doc/interval_meter.md
# interval_meter

Measures the number of `clk` cycles between a rising edge on `start` and the next rising edge on `stop`, both asynchronous to `clk`, and holds the result until software acknowledges it with `clear`. It is the measuring counterpart of the delay-generation timer in the same PL timing subsystem: where that block produces `done` after a programmed count, this block times an externally produced interval. It typically sits behind an AXI-Lite register wrapper, or directly on the loop `start` → delay timer → `done` → `stop` for self-calibration.

## Interface
- `C_COUNTER_WIDTH`, 32: width of the internal counter and of `interval`.
- `C_SYNC_STAGES`, 2 (range 2–4): synchronizer depth on `start`, `stop` and `clear`.

- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  asynchronous level; a rising edge begins a measurement.
- `stop`  in  1  asynchronous level; a rising edge ends a measurement.
- `clear`  in  1  asynchronous level; a rising edge acknowledges or aborts.
- `interval`  out  `C_COUNTER_WIDTH`  captured cycle count; valid while `valid`=1.
- `valid`  out  1  a result is held.
- `busy`  out  1  a measurement is in progress.
- `overflow`  out  1  the counter saturated during the held measurement.

## Operation
- **Input conditioning.** Each async input passes through `C_SYNC_STAGES` flops, then a one-flop edge detector. This produces internal one-cycle pulses `start_p`, `stop_p` and `clear_p`. All of these flops reset to 0, so a level held high across reset release yields exactly one pulse.
- **FSM states:** IDLE, COUNT, HOLD.
  - **IDLE:** on `start_p`, set `count` ← 1 and go to COUNT. `stop_p` alone is ignored. If `start_p` and `stop_p` arrive together, start wins and stop is discarded.
  - **COUNT:** if `stop_p`, set `interval` ← `count` and go to HOLD. Otherwise `count` ← `count`+1, saturating at all-ones. On saturation set the `overflow` flag. `start_p` is ignored in COUNT; there is no retrigger.
  - **HOLD:** `interval`, `valid` and `overflow` are frozen. Both `start_p` and `stop_p` are ignored.
- **Clear.** `clear_p` in any state returns the FSM to IDLE and zeroes `count`, `interval`, `valid` and `overflow`. `clear_p` has priority over `start_p` and `stop_p` in the same cycle.
- **Reset.** `reset` has priority over everything. All outputs reset to 0 and the FSM to IDLE. Reset mid-measurement discards that measurement.
- **Output decode.** `busy` = (state==COUNT). `valid` = (state==HOLD). Both are registered-state decodes with no combinational path from inputs.
- **Interval definition.** If `start_p` is high at cycle t0 and `stop_p` at cycle t1, then `interval` = t1 − t0.
  - Minimum result is 1.
  - Saturated result is 2^W − 1, with `overflow`=1.

## Timing
- Input edge to internal pulse: a rising edge first sampled at clk edge k gives a pulse during the cycle after edge k+`C_SYNC_STAGES`−1. This latency is identical for all three inputs, so it cancels in `interval`.
- Inputs must stay high and stay low each for at least `C_SYNC_STAGES`+1 cycles to be reliably detected. Shorter pulses may be missed and that is legal.
- `stop_p` at cycle t1: `interval` and `valid` update at the edge ending t1, and are visible in cycle t1+1. `busy` falls in the same cycle.
- `start_p` at t0: `busy`=1 from t0+1.
- `clear_p` at tc: all outputs read 0 from tc+1. A `start_p` at tc+1 is accepted.
- A counter at all-ones stays at all-ones. `overflow` rises in the cycle after `count` first reaches all-ones.

## Test plan
- Basic measurement, W=32: raise `start`, then raise `stop` exactly 100 cycles later. Expect `interval`=100, `valid`=1, `busy`=0, `overflow`=0. Pulse `clear` and expect all outputs 0 one cycle after `clear_p`.
- Minimum interval: the `stop` edge lands 1 cycle after the `start` edge at the synchronizer inputs. Expect `interval`=1. With both edges in the same cycle, expect no capture, `busy`=1; then a later `stop` 20 cycles after `start` gives `interval`=20.
- Overflow, W=8: `stop` arrives 300 cycles after `start`. Expect `overflow`=1 and `interval`=255.
- Ignored events: a second `start` edge during COUNT leaves the result referenced to the first edge. `start` and `stop` edges during HOLD leave `interval` unchanged. A `stop` edge in IDLE leaves `valid`=0.
- Clear and reset mid-count: `clear` at 50 cycles into a measurement gives `busy`=0 and `valid`=0. A new 30-cycle measurement then yields 30. Repeat with `reset` asserted for 1 cycle and expect the same outcome.
- Back-to-back: measure 10 cycles, clear, then measure 1000 cycles. Expect 10 and then 1000, with no residual `overflow`.
